// File: rtl/pulse_train_bank.sv
// pulse_train_bank: per-channel delayed, fine-edged pulse generator feeding the EVR output SERDES.
// Optional feature macro: PULSE_TRAIN_EN adds N-repeat trains separated by a programmable zero gap.
module pulse_train_bank #(
    parameter int CHANNELS           = 4,
    parameter int SERDES_WIDTH       = 4,
    parameter int COARSE_DELAY_WIDTH = 22,
    parameter int COARSE_WIDTH_WIDTH = 20,
    parameter int TRAIN_COUNT_WIDTH  = 8,
    localparam int CHAN_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             evrClk,
    input  logic                             evrRst_n,
    input  logic                             cfgStrobe,
    input  logic [CHAN_W-1:0]                cfgChannel,
    input  logic [1:0]                       cfgOp,
    input  logic [31:0]                      cfgData,
    input  logic [CHANNELS-1:0]              triggerStrobe,
    output logic [CHANNELS-1:0]              busy,
    output logic [CHANNELS*SERDES_WIDTH-1:0] serdesPattern
);

    localparam int GAP_WIDTH = 20;
    localparam int LEN_W0    = (COARSE_DELAY_WIDTH > COARSE_WIDTH_WIDTH) ? COARSE_DELAY_WIDTH : COARSE_WIDTH_WIDTH;
    localparam int LEN_W     = (LEN_W0 > GAP_WIDTH) ? LEN_W0 : GAP_WIDTH;
    localparam int CNT_W     = LEN_W + 1;

    localparam logic [1:0] OP_CONTROL = 2'd0;
    localparam logic [1:0] OP_DELAY   = 2'd1;
    localparam logic [1:0] OP_WIDTH   = 2'd2;
    localparam logic [1:0] OP_PERIOD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } chState_t;

    // A length L is counted as L-1 down to -1; the MSB going high marks completion.
    function automatic logic [CNT_W-1:0] loadCount(input logic [LEN_W-1:0] len);
        return {1'b0, len} - CNT_W'(1'b1);
    endfunction

    logic unusedCfg;
    assign unusedCfg = ^cfgData;

    for (genvar c = 0; c < CHANNELS; c++) begin : gCh
        logic                          shEn, shInv, shRetrig;
        logic [SERDES_WIDTH-1:0]       shFirst, shLast;
        logic [COARSE_DELAY_WIDTH-1:0] shDelay;
        logic [COARSE_WIDTH_WIDTH-1:0] shWidth;
        logic                          actInv;
        logic [SERDES_WIDTH-1:0]       actFirst, actLast;
        logic [COARSE_WIDTH_WIDTH-1:0] actWidth;
        chState_t                      state, stateNext;
        logic [CNT_W-1:0]              cnt, cntNext;
        logic [SERDES_WIDTH-1:0]       word, wordNext, invMask;
        logic                          busyR, busyNext;
        logic                          wrSel, abort, accept, loadAct, finish, cntNeg;
`ifdef PULSE_TRAIN_EN
        logic [TRAIN_COUNT_WIDTH-1:0]  shTrain, trainCnt, trainNext;
        logic [GAP_WIDTH-1:0]          shGap, actGap;
`endif

        assign wrSel   = cfgStrobe && (cfgChannel == CHAN_W'(c));
        assign abort   = wrSel && (cfgOp == OP_CONTROL) && !cfgData[0];
        assign accept  = triggerStrobe[c] && shEn && ((state == ST_IDLE) || shRetrig);
        assign cntNeg  = cnt[CNT_W-1];
        assign invMask = {SERDES_WIDTH{actInv}};

        // Next-state, counter and output-word decode; disable beats trigger, trigger beats sequencing.
        always_comb begin
            stateNext = state;
            cntNext   = cnt;
            wordNext  = invMask;
            loadAct   = 1'b0;
            finish    = 1'b0;
`ifdef PULSE_TRAIN_EN
            trainNext = trainCnt;
`endif
            if (abort) begin
                stateNext = ST_IDLE;
                wordNext  = {SERDES_WIDTH{cfgData[1]}};
            end else if (accept) begin
                loadAct   = 1'b1;
                stateNext = ST_DELAY;
                cntNext   = loadCount(LEN_W'(shDelay));
                wordNext  = {SERDES_WIDTH{shInv}};
`ifdef PULSE_TRAIN_EN
                trainNext = shTrain;
`endif
            end else begin
                case (state)
                    ST_IDLE: wordNext = {SERDES_WIDTH{shInv}};
                    ST_DELAY, ST_GAP: begin
                        if (cntNeg) begin
                            stateNext = ST_PULSE;
                            cntNext   = loadCount(LEN_W'(actWidth));
                            wordNext  = actFirst ^ invMask;
                        end else begin
                            cntNext   = cnt - CNT_W'(1'b1);
                        end
                    end
                    ST_PULSE: begin
                        if (!cntNeg) begin
                            wordNext = ~invMask;
                            cntNext  = cnt - CNT_W'(1'b1);
                        end else begin
                            wordNext = actLast ^ invMask;
`ifdef PULSE_TRAIN_EN
                            if (trainCnt == {TRAIN_COUNT_WIDTH{1'b0}}) begin
                                stateNext = ST_IDLE;
                                finish    = 1'b1;
                            end else begin
                                trainNext = trainCnt - TRAIN_COUNT_WIDTH'(1'b1);
                                cntNext   = loadCount(LEN_W'(actGap));
                                stateNext = ST_GAP;
                            end
`else
                            stateNext = ST_IDLE;
                            finish    = 1'b1;
`endif
                        end
                    end
                    default: stateNext = ST_IDLE;
                endcase
            end
            // busy stays up for the cycle the final lastPattern is on the wire
            busyNext = (stateNext != ST_IDLE) || finish;
        end

        // FSM state, counters and registered outputs.
        always_ff @(posedge evrClk or negedge evrRst_n) begin
            if (!evrRst_n) begin
                state    <= ST_IDLE;
                cnt      <= {CNT_W{1'b0}};
                word     <= {SERDES_WIDTH{1'b0}};
                busyR    <= 1'b0;
`ifdef PULSE_TRAIN_EN
                trainCnt <= {TRAIN_COUNT_WIDTH{1'b0}};
`endif
            end else begin
                state    <= stateNext;
                cnt      <= cntNext;
                word     <= wordNext;
                busyR    <= busyNext;
`ifdef PULSE_TRAIN_EN
                trainCnt <= trainNext;
`endif
            end
        end

        // Shadow registers take writes; active copies latch the pre-write shadows on an accepted trigger.
        always_ff @(posedge evrClk or negedge evrRst_n) begin
            if (!evrRst_n) begin
                shEn     <= 1'b0;
                shInv    <= 1'b0;
                shRetrig <= 1'b0;
                shFirst  <= {SERDES_WIDTH{1'b0}};
                shLast   <= {SERDES_WIDTH{1'b0}};
                shDelay  <= {COARSE_DELAY_WIDTH{1'b0}};
                shWidth  <= {COARSE_WIDTH_WIDTH{1'b0}};
                actInv   <= 1'b0;
                actFirst <= {SERDES_WIDTH{1'b0}};
                actLast  <= {SERDES_WIDTH{1'b0}};
                actWidth <= {COARSE_WIDTH_WIDTH{1'b0}};
`ifdef PULSE_TRAIN_EN
                shTrain  <= {TRAIN_COUNT_WIDTH{1'b0}};
                shGap    <= {GAP_WIDTH{1'b0}};
                actGap   <= {GAP_WIDTH{1'b0}};
`endif
            end else begin
                if (loadAct) begin
                    actInv   <= shInv;
                    actFirst <= shFirst;
                    actLast  <= shLast;
                    actWidth <= shWidth;
`ifdef PULSE_TRAIN_EN
                    actGap   <= shGap;
`endif
                end
                if (wrSel) begin
                    case (cfgOp)
                        OP_CONTROL: begin
                            shEn     <= cfgData[0];
                            shInv    <= cfgData[1];
                            shRetrig <= cfgData[2];
`ifdef PULSE_TRAIN_EN
                            shTrain  <= cfgData[8 +: TRAIN_COUNT_WIDTH];
`endif
                        end
                        OP_DELAY: begin
                            shFirst <= cfgData[SERDES_WIDTH-1:0];
                            shDelay <= cfgData[SERDES_WIDTH +: COARSE_DELAY_WIDTH];
                        end
                        OP_WIDTH: begin
                            shLast  <= cfgData[SERDES_WIDTH-1:0];
                            shWidth <= cfgData[SERDES_WIDTH +: COARSE_WIDTH_WIDTH];
                        end
`ifdef PULSE_TRAIN_EN
                        OP_PERIOD: shGap <= cfgData[GAP_WIDTH-1:0];
`endif
                        default: ;
                    endcase
                end
            end
        end

        assign busy[c]                                     = busyR;
        assign serdesPattern[c*SERDES_WIDTH +: SERDES_WIDTH] = word;
    end

endmodule

// File: tb/tb_pulse_train_bank.sv
// Directed self-checking bench for pulse_train_bank (default parameters, 4 channels x 4-bit words).
module tb_pulse_train_bank;

`ifdef PULSE_TRAIN_EN
    localparam int TRAIN_PULSES = 3;
`else
    localparam int TRAIN_PULSES = 1;
`endif
    localparam logic [3:0] INV_EXP    [0:3]  = '{4'hF, 4'hA, 4'h6, 4'hF};
    localparam logic [3:0] RETRIG_EXP [0:10] = '{4'h0, 4'h0, 4'h6, 4'hF, 4'h0, 4'h0,
                                                 4'h7, 4'hF, 4'hF, 4'h3, 4'h0};

    logic        evrClk;
    logic        evrRst_n;
    logic        cfgStrobe;
    logic [1:0]  cfgChannel;
    logic [1:0]  cfgOp;
    logic [31:0] cfgData;
    logic [3:0]  triggerStrobe;
    logic [3:0]  busy;
    logic [15:0] serdesPattern;

    int checks = 0;
    int errors = 0;

    pulse_train_bank dut (
        .evrClk        (evrClk),
        .evrRst_n      (evrRst_n),
        .cfgStrobe     (cfgStrobe),
        .cfgChannel    (cfgChannel),
        .cfgOp         (cfgOp),
        .cfgData       (cfgData),
        .triggerStrobe (triggerStrobe),
        .busy          (busy),
        .serdesPattern (serdesPattern)
    );

    initial evrClk = 1'b0;
    always #5 evrClk = ~evrClk;

    task automatic tick();
        @(posedge evrClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkLane(input string tag, input int ch, input logic [3:0] exp);
        logic [3:0] lane;
        lane = serdesPattern[ch*4 +: 4];
        check(tag, {12'h000, lane}, {12'h000, exp});
    endtask

    task automatic checkBusy(input string tag, input int ch, input logic exp);
        check(tag, {15'h0000, busy[ch]}, {15'h0000, exp});
    endtask

    task automatic cfgWrite(input logic [1:0] ch, input logic [1:0] op, input logic [31:0] data);
        cfgStrobe  = 1'b1;
        cfgChannel = ch;
        cfgOp      = op;
        cfgData    = data;
        tick();
        cfgStrobe  = 1'b0;
    endtask

    function automatic logic [3:0] exp0(input int k);
        if (k == 5) return 4'hC;
        else if (k == 6 || k == 7) return 4'hF;
        else if (k == 8) return 4'h3;
        else return 4'h0;
    endfunction

    function automatic logic [3:0] trainExp(input int k);
        if (k >= 2 && (k - 2) / 4 < TRAIN_PULSES) begin
            case ((k - 2) % 4)
                0: return 4'h8;
                1: return 4'hF;
                2: return 4'h1;
                default: return 4'h0;
            endcase
        end
        return 4'h0;
    endfunction

    initial begin
        evrRst_n      = 1'b0;
        cfgStrobe     = 1'b0;
        cfgChannel    = 2'd0;
        cfgOp         = 2'd0;
        cfgData       = 32'h0;
        triggerStrobe = 4'h0;
        tick();
        tick();
        check("rst_pattern", serdesPattern, 16'h0000);
        check("rst_busy", {12'h000, busy}, 16'h0000);
        evrRst_n = 1'b1;
        tick();

        // ch0: D=3 W=2 first=1100 last=0011
        cfgWrite(2'd0, 2'd1, 32'h0000_003C);
        cfgWrite(2'd0, 2'd2, 32'h0000_0023);
        cfgWrite(2'd0, 2'd0, 32'h0000_0001);
        triggerStrobe = 4'b0001; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            checkLane($sformatf("basic_word_k%0d", k), 0, exp0(k));
            checkBusy($sformatf("basic_busy_k%0d", k), 0, (k <= 8) ? 1'b1 : 1'b0);
            tick();
        end

        // ch2: D=0 W=0 inverted
        cfgWrite(2'd2, 2'd0, 32'h0000_0003);
        cfgWrite(2'd2, 2'd1, 32'h0000_0005);
        cfgWrite(2'd2, 2'd2, 32'h0000_0009);
        checkLane("inv_idle", 2, 4'hF);
        triggerStrobe = 4'b0100; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            checkLane($sformatf("inv_word_k%0d", k), 2, INV_EXP[k-1]);
            checkBusy($sformatf("inv_busy_k%0d", k), 2, (k <= 3) ? 1'b1 : 1'b0);
            tick();
        end

        // ch1: train N=2 G=1 W=1 D=0
        cfgWrite(2'd1, 2'd1, 32'h0000_0008);
        cfgWrite(2'd1, 2'd2, 32'h0000_0011);
        cfgWrite(2'd1, 2'd3, 32'h0000_0001);
        cfgWrite(2'd1, 2'd0, 32'h0000_0201);
        triggerStrobe = 4'b0010; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 13; k++) begin
            checkLane($sformatf("train_word_k%0d", k), 1, trainExp(k));
            checkBusy($sformatf("train_busy_k%0d", k), 1, (k <= 4 * TRAIN_PULSES) ? 1'b1 : 1'b0);
            tick();
        end

        // ch0 retrigger disabled: second trigger mid-pulse is ignored
        triggerStrobe = 4'b0001; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            checkLane($sformatf("noretrig_word_k%0d", k), 0, exp0(k));
            checkBusy($sformatf("noretrig_busy_k%0d", k), 0, (k <= 8) ? 1'b1 : 1'b0);
            if (k == 6) triggerStrobe = 4'b0001;
            tick();
            triggerStrobe = 4'b0000;
        end

        // ch0 retrigger enabled, D=1; new first pattern written mid-pulse
        cfgWrite(2'd0, 2'd0, 32'h0000_0005);
        cfgWrite(2'd0, 2'd1, 32'h0000_0016);
        triggerStrobe = 4'b0001; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 11; k++) begin
            checkLane($sformatf("retrig_word_k%0d", k), 0, RETRIG_EXP[k-1]);
            checkBusy($sformatf("retrig_busy_k%0d", k), 0, (k <= 10) ? 1'b1 : 1'b0);
            if (k == 2) begin
                cfgStrobe = 1'b1; cfgChannel = 2'd0; cfgOp = 2'd1; cfgData = 32'h0000_0017;
            end
            if (k == 4) triggerStrobe = 4'b0001;
            tick();
            cfgStrobe     = 1'b0;
            triggerStrobe = 4'b0000;
        end

        // ch3 aborted mid-delay while ch0 runs undisturbed
        cfgWrite(2'd0, 2'd0, 32'h0000_0001);
        cfgWrite(2'd0, 2'd1, 32'h0000_003C);
        cfgWrite(2'd3, 2'd1, 32'h0000_005F);
        cfgWrite(2'd3, 2'd2, 32'h0000_001A);
        cfgWrite(2'd3, 2'd0, 32'h0000_0001);
        triggerStrobe = 4'b1001; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            checkLane($sformatf("abort_ch0_word_k%0d", k), 0, exp0(k));
            checkBusy($sformatf("abort_ch0_busy_k%0d", k), 0, (k <= 8) ? 1'b1 : 1'b0);
            checkLane($sformatf("abort_ch3_word_k%0d", k), 3, 4'h0);
            checkBusy($sformatf("abort_ch3_busy_k%0d", k), 3, (k <= 2) ? 1'b1 : 1'b0);
            if (k == 2) begin
                cfgStrobe = 1'b1; cfgChannel = 2'd3; cfgOp = 2'd0; cfgData = 32'h0000_0000;
            end
            tick();
            cfgStrobe = 1'b0;
        end

        // reset asserted mid-pulse on ch0
        triggerStrobe = 4'b0001; tick(); triggerStrobe = 4'b0000;
        for (int k = 1; k <= 5; k++) tick();
        checkLane("prerst_word_k6", 0, 4'hF);
        evrRst_n = 1'b0;
        #1;
        check("midrst_pattern", serdesPattern, 16'h0000);
        check("midrst_busy", {12'h000, busy}, 16'h0000);
        tick();
        evrRst_n = 1'b1;
        tick();
        triggerStrobe = 4'b0001; tick(); triggerStrobe = 4'b0000;
        checkBusy("postrst_busy_k1", 0, 1'b0);
        tick();
        checkBusy("postrst_busy_k2", 0, 1'b0);
        checkLane("postrst_word_k2", 0, 4'h0);

        // trigger with simultaneous DELAY write uses pre-write D=0
        cfgWrite(2'd0, 2'd0, 32'h0000_0001);
        cfgStrobe = 1'b1; cfgChannel = 2'd0; cfgOp = 2'd1; cfgData = 32'h0000_002E;
        triggerStrobe = 4'b0001;
        tick();
        cfgStrobe = 1'b0; triggerStrobe = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            checkLane($sformatf("prewrite_word_k%0d", k), 0, 4'h0);
            checkBusy($sformatf("prewrite_busy_k%0d", k), 0, (k <= 3) ? 1'b1 : 1'b0);
            tick();
        end

        // trigger and disable in the same cycle: disable wins
        cfgWrite(2'd3, 2'd0, 32'h0000_0001);
        cfgStrobe = 1'b1; cfgChannel = 2'd3; cfgOp = 2'd0; cfgData = 32'h0000_0000;
        triggerStrobe = 4'b1000;
        tick();
        cfgStrobe = 1'b0; triggerStrobe = 4'b0000;
        checkBusy("disable_wins_k1", 3, 1'b0);
        tick();
        checkBusy("disable_wins_k2", 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
